// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: CDB widths, ALU opcodes and the reservation-station entry layout.
package tomasulo_pkg;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest;
    logic             j_pend;
    logic [TAG_W-1:0] qj;
    logic [XLEN-1:0]  vj;
    logic             k_pend;
    logic [TAG_W-1:0] qk;
    logic [XLEN-1:0]  vk;
  } rs_entry_t;

  // True when a pending operand is satisfied by the broadcast on the CDB this cycle.
  function automatic logic tag_hit(input logic             pend,
                                   input logic [TAG_W-1:0] q,
                                   input logic             cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag);
    return pend & cdb_valid & (q == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// One-hot lowest-set-bit picker used for free-slot and ready-entry selection.
module rs_pick_lowest #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] gnt_c,
  output logic             any_c
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_c = req & (~req + DEPTH'(1));
  assign any_c = |req;

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched ops, captures operands from the CDB by tag,
// and issues the lowest-index ready entry to the functional unit.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             disp_j_pend,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic             disp_k_pend,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [OP_W-1:0]  issue_op,
  output logic [XLEN-1:0]  issue_vj,
  output logic [XLEN-1:0]  issue_vk,
  output logic [TAG_W-1:0] issue_dest
);

  rs_entry_t        ent [DEPTH];
  rs_entry_t        disp_entry;
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] issue_oh;
  logic             any_free;
  logic             any_ready;
  logic             disp_fire;
  logic             issue_fire;

  // Occupancy and readiness straight from registered entry state.
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy & ~ent[i].j_pend & ~ent[i].k_pend;
    end
  end

  assign free_vec = ~busy_vec;

  rs_pick_lowest #(.DEPTH(DEPTH)) u_pick_free (
    .req   (free_vec),
    .gnt_c (free_oh),
    .any_c (any_free)
  );

  rs_pick_lowest #(.DEPTH(DEPTH)) u_pick_ready (
    .req   (ready_vec),
    .gnt_c (issue_oh),
    .any_c (any_ready)
  );

  assign disp_ready  = any_free;
  assign disp_fire   = disp_valid & any_free;
  assign issue_valid = any_ready;
  assign issue_fire  = any_ready & issue_ready;

  // New entry image, with operands bypassed from a same-cycle broadcast.
  always_comb begin
    disp_entry        = '0;
    disp_entry.busy   = 1'b1;
    disp_entry.op     = disp_op;
    disp_entry.dest   = disp_dest;
    disp_entry.j_pend = disp_j_pend;
    disp_entry.qj     = disp_qj;
    disp_entry.vj     = disp_vj;
    disp_entry.k_pend = disp_k_pend;
    disp_entry.qk     = disp_qk;
    disp_entry.vk     = disp_vk;
    if (tag_hit(disp_j_pend, disp_qj, cdb_valid, cdb_tag)) begin
      disp_entry.j_pend = 1'b0;
      disp_entry.vj     = cdb_value;
    end
    if (tag_hit(disp_k_pend, disp_qk, cdb_valid, cdb_tag)) begin
      disp_entry.k_pend = 1'b0;
      disp_entry.vk     = cdb_value;
    end
  end

  // One-hot AND-OR mux; all-zero when nothing is ready.
  always_comb begin
    issue_op   = '0;
    issue_vj   = '0;
    issue_vk   = '0;
    issue_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issue_op   = issue_op   | ({OP_W{issue_oh[i]}}  & ent[i].op);
      issue_vj   = issue_vj   | ({XLEN{issue_oh[i]}}  & ent[i].vj);
      issue_vk   = issue_vk   | ({XLEN{issue_oh[i]}}  & ent[i].vk);
      issue_dest = issue_dest | ({TAG_W{issue_oh[i]}} & ent[i].dest);
    end
  end

  // Entry update: issue frees, dispatch fills a free slot, busy entries snoop the CDB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].busy <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_fire && issue_oh[i]) begin
          ent[i].busy <= 1'b0;
        end else if (disp_fire && free_oh[i]) begin
          ent[i] <= disp_entry;
        end else if (ent[i].busy) begin
          if (tag_hit(ent[i].j_pend, ent[i].qj, cdb_valid, cdb_tag)) begin
            ent[i].j_pend <= 1'b0;
            ent[i].vj     <= cdb_value;
          end
          if (tag_hit(ent[i].k_pend, ent[i].qk, cdb_valid, cdb_tag)) begin
            ent[i].k_pend <= 1'b0;
            ent[i].vk     <= cdb_value;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus randomized traffic
// compared each cycle against an array-based reference model.
module tb_reservation_station;
  import tomasulo_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_dest;
  logic             disp_j_pend;
  logic [TAG_W-1:0] disp_qj;
  logic [XLEN-1:0]  disp_vj;
  logic             disp_k_pend;
  logic [TAG_W-1:0] disp_qk;
  logic [XLEN-1:0]  disp_vk;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [XLEN-1:0]  issue_vj;
  logic [XLEN-1:0]  issue_vk;
  logic [TAG_W-1:0] issue_dest;

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_op     (disp_op),
    .disp_dest   (disp_dest),
    .disp_j_pend (disp_j_pend),
    .disp_qj     (disp_qj),
    .disp_vj     (disp_vj),
    .disp_k_pend (disp_k_pend),
    .disp_qk     (disp_qk),
    .disp_vk     (disp_vk),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .issue_dest  (issue_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: slot-indexed list of waiting ops.
  bit               m_busy [DEPTH];
  logic [OP_W-1:0]  m_op   [DEPTH];
  logic [TAG_W-1:0] m_dest [DEPTH];
  bit               m_jp   [DEPTH];
  logic [TAG_W-1:0] m_qj   [DEPTH];
  logic [XLEN-1:0]  m_vj   [DEPTH];
  bit               m_kp   [DEPTH];
  logic [TAG_W-1:0] m_qk   [DEPTH];
  logic [XLEN-1:0]  m_vk   [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_ready_idx();
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && !m_jp[i] && !m_kp[i]) return i;
    return -1;
  endfunction

  function automatic int model_free_idx();
    for (int i = 0; i < DEPTH; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic compare_outputs(input string tag);
    int ri;
    ri = model_ready_idx();
    check({tag, ".disp_ready"},  64'(disp_ready),  64'(model_free_idx() >= 0));
    check({tag, ".issue_valid"}, 64'(issue_valid), 64'(ri >= 0));
    check({tag, ".issue_op"},    64'(issue_op),    (ri >= 0) ? 64'(m_op[ri])   : 64'd0);
    check({tag, ".issue_vj"},    64'(issue_vj),    (ri >= 0) ? 64'(m_vj[ri])   : 64'd0);
    check({tag, ".issue_vk"},    64'(issue_vk),    (ri >= 0) ? 64'(m_vk[ri])   : 64'd0);
    check({tag, ".issue_dest"},  64'(issue_dest),  (ri >= 0) ? 64'(m_dest[ri]) : 64'd0);
  endtask

  // Advance the model across one clock edge using the inputs held during that cycle.
  task automatic model_step();
    int ri;
    int fi;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      return;
    end
    ri = model_ready_idx();
    fi = model_free_idx();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && cdb_valid && m_jp[i] && m_qj[i] == cdb_tag) begin
        m_jp[i] = 0; m_vj[i] = cdb_value;
      end
      if (m_busy[i] && cdb_valid && m_kp[i] && m_qk[i] == cdb_tag) begin
        m_kp[i] = 0; m_vk[i] = cdb_value;
      end
    end
    if (ri >= 0 && issue_ready) m_busy[ri] = 0;
    if (disp_valid && fi >= 0) begin
      m_busy[fi] = 1;
      m_op[fi]   = disp_op;
      m_dest[fi] = disp_dest;
      m_jp[fi]   = disp_j_pend;
      m_qj[fi]   = disp_qj;
      m_vj[fi]   = disp_vj;
      m_kp[fi]   = disp_k_pend;
      m_qk[fi]   = disp_qk;
      m_vk[fi]   = disp_vk;
      if (cdb_valid && disp_j_pend && disp_qj == cdb_tag) begin
        m_jp[fi] = 0; m_vj[fi] = cdb_value;
      end
      if (cdb_valid && disp_k_pend && disp_qk == cdb_tag) begin
        m_kp[fi] = 0; m_vk[fi] = cdb_value;
      end
    end
  endtask

  task automatic cycle(input string tag);
    compare_outputs(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; cdb_valid = 0; issue_ready = 0;
    disp_op = '0; disp_dest = '0; disp_j_pend = 0; disp_qj = '0; disp_vj = '0;
    disp_k_pend = 0; disp_qk = '0; disp_vk = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                          input logic jp, input logic [TAG_W-1:0] qj, input logic [XLEN-1:0] vj,
                          input logic kp, input logic [TAG_W-1:0] qk, input logic [XLEN-1:0] vk);
    disp_valid = 1; disp_op = op; disp_dest = dest;
    disp_j_pend = jp; disp_qj = qj; disp_vj = vj;
    disp_k_pend = kp; disp_qk = qk; disp_vk = vk;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val;
  endtask

  function automatic logic [TAG_W-1:0] rand_tag();
    if ($urandom_range(0, 15) == 0) return TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    return TAG_W'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("reset.disp_ready",  64'(disp_ready),  64'd1);
    check("reset.issue_valid", 64'(issue_valid), 64'd0);
    check("reset.issue_vj",    64'(issue_vj),    64'd0);
    check("reset.issue_dest",  64'(issue_dest),  64'd0);
    cycle("reset");
    idle();

    // 1: ready-at-dispatch op issues the next cycle, then frees its slot
    set_disp(4'(ALU_ADD), 5'd1, 0, '0, 32'd5, 0, '0, 32'd7);
    cycle("t1.disp");
    idle();
    check("t1.issue_valid", 64'(issue_valid), 64'd1);
    check("t1.issue_vj",    64'(issue_vj),    64'd5);
    check("t1.issue_vk",    64'(issue_vk),    64'd7);
    issue_ready = 1;
    cycle("t1.accept");
    idle();
    check("t1.freed", 64'(issue_valid), 64'd0);
    cycle("t1.idle");

    // 2: pending src1 ignores a non-matching tag, then captures
    set_disp(4'(ALU_SUB), 5'd2, 1, 5'd3, '0, 0, '0, 32'd9);
    cycle("t2.disp");
    idle(); set_cdb(5'd4, 32'h1111_1111);
    cycle("t2.cdb4");
    idle();
    check("t2.still_pend", 64'(issue_valid), 64'd0);
    set_cdb(5'd3, 32'hDEAD_BEEF);
    cycle("t2.cdb3");
    idle();
    check("t2.issue_valid", 64'(issue_valid), 64'd1);
    check("t2.issue_vj",    64'(issue_vj),    64'hDEAD_BEEF);
    issue_ready = 1;
    cycle("t2.accept");
    idle();

    // 3: dispatch-cycle bypass from the CDB
    set_disp(4'(ALU_AND), 5'd3, 1, 5'd9, '0, 0, '0, 32'd1);
    set_cdb(5'd9, 32'h42);
    cycle("t3.bypass");
    idle();
    check("t3.issue_valid", 64'(issue_valid), 64'd1);
    check("t3.issue_vj",    64'(issue_vj),    64'h42);
    issue_ready = 1;
    cycle("t3.accept");
    idle();

    // 4: fill, overflow dispatch ignored, one broadcast wakes both operands of entry 2
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 2) set_disp(4'(ALU_OR), 5'd22, 1, 5'd15, '0, 1, 5'd15, '0);
      else        set_disp(4'(ALU_XOR), 5'(20 + i), 1, 5'(10 + i), '0, 1, 5'(24 + i), '0);
      cycle("t4.fill");
    end
    idle();
    check("t4.full", 64'(disp_ready), 64'd0);
    set_disp(4'(ALU_SLL), 5'd31, 0, '0, 32'd1, 0, '0, 32'd2);
    cycle("t4.overflow");
    idle();
    check("t4.still_full", 64'(disp_ready), 64'd0);
    set_cdb(5'd15, 32'h0ABC);
    cycle("t4.wake");
    idle();
    check("t4.issue_dest", 64'(issue_dest), 64'd22);
    check("t4.issue_vj",   64'(issue_vj),   64'h0ABC);
    check("t4.issue_vk",   64'(issue_vk),   64'h0ABC);
    issue_ready = 1;
    cycle("t4.accept");
    idle(); flush = 1;
    cycle("t4.clear");
    idle();

    // 5: ready entries at 1 and 3 held under backpressure
    set_disp(4'(ALU_ADD), 5'h10, 1, 5'd30, '0, 0, '0, 32'd0);  cycle("t5.d0");
    set_disp(4'(ALU_SUB), 5'h11, 0, '0, 32'd11, 0, '0, 32'd1); cycle("t5.d1");
    set_disp(4'(ALU_ADD), 5'h12, 1, 5'd31, '0, 0, '0, 32'd0);  cycle("t5.d2");
    set_disp(4'(ALU_SRA), 5'h13, 0, '0, 32'd13, 0, '0, 32'd3); cycle("t5.d3");
    idle();
    for (int i = 0; i < 3; i++) begin
      check("t5.hold_dest", 64'(issue_dest), 64'h11);
      cycle("t5.hold");
    end
    issue_ready = 1;
    cycle("t5.accept");
    idle();
    check("t5.next_dest", 64'(issue_dest), 64'h13);
    check("t5.next_vj",   64'(issue_vj),   64'd13);

    // 6: flush with three busy entries and a concurrent dispatch
    flush = 1;
    set_disp(4'(ALU_ADD), 5'd7, 0, '0, 32'd1, 0, '0, 32'd1);
    cycle("t6.flush");
    idle();
    check("t6.disp_ready",  64'(disp_ready),  64'd1);
    check("t6.issue_valid", 64'(issue_valid), 64'd0);
    cycle("t6.after");

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 63) == 0);
      disp_valid  = $urandom_range(0, 1) == 1;
      disp_op     = OP_W'($urandom_range(0, 15));
      disp_dest   = rand_tag();
      disp_j_pend = $urandom_range(0, 1) == 1;
      disp_qj     = rand_tag();
      disp_vj     = $urandom;
      disp_k_pend = $urandom_range(0, 1) == 1;
      disp_qk     = rand_tag();
      disp_vk     = $urandom;
      cdb_valid   = $urandom_range(0, 1) == 1;
      cdb_tag     = rand_tag();
      cdb_value   = $urandom;
      issue_ready = $urandom_range(0, 9) < 6;
      cycle("rand");
    end
    idle();
    cycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
